// File: rtl/tl_d_beat_tracker_if.sv
// D-channel beat tracker bus: alloc side, response header in, per-beat metadata out,
// source free pulse and sticky error flags.
interface tl_d_beat_tracker_if #(
    parameter int SOURCE_BITS = 7,
    parameter int CNT_W       = 9
);
    logic                   alloc_valid;
    logic [SOURCE_BITS-1:0] alloc_source;
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_opcode;
    logic [3:0]             in_size;
    logic [SOURCE_BITS-1:0] in_source;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             out_opcode;
    logic [SOURCE_BITS-1:0] out_source;
    logic [CNT_W-1:0]       out_beat;
    logic                   out_first;
    logic                   out_last;
    logic                   free_valid;
    logic [SOURCE_BITS-1:0] free_source;
    logic                   err_unexpected;
    logic                   err_interleave;
    logic                   err_size;

    modport master (
        output alloc_valid, alloc_source, in_valid, in_opcode, in_size, in_source, out_ready,
        input  in_ready, out_valid, out_opcode, out_source, out_beat, out_first, out_last,
               free_valid, free_source, err_unexpected, err_interleave, err_size
    );

    modport slave (
        input  alloc_valid, alloc_source, in_valid, in_opcode, in_size, in_source, out_ready,
        output in_ready, out_valid, out_opcode, out_source, out_beat, out_first, out_last,
               free_valid, free_source, err_unexpected, err_interleave, err_size
    );
endinterface

// File: rtl/tl_d_beat_tracker.sv
// Expands D-channel response headers into registered per-beat metadata, tracks
// in-flight sources in a bitmap and raises sticky protocol-violation flags.
module tl_d_beat_tracker #(
    parameter int SOURCE_BITS     = 7,
    parameter int BEAT_BYTES_LOG2 = 3,
    parameter int MAX_SIZE_LOG2   = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    tl_d_beat_tracker_if.slave   bus
);
    localparam int              CNT_W  = MAX_SIZE_LOG2 - BEAT_BYTES_LOG2;
    localparam int              NSRC   = 2 ** SOURCE_BITS;
    localparam logic [3:0]      MAX_SZ = 4'(MAX_SIZE_LOG2);
    localparam logic [3:0]      BB_SZ  = 4'(BEAT_BYTES_LOG2);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SOURCE_BITS-1:0] r_burst_src;
    logic [NSRC-1:0]        r_bitmap;
    logic                   r_out_valid;
    logic [2:0]             r_out_opcode;
    logic [SOURCE_BITS-1:0] r_out_source;
    logic [CNT_W-1:0]       r_out_beat;
    logic                   r_out_first;
    logic                   r_out_last;
    logic                   r_free_valid;
    logic [SOURCE_BITS-1:0] r_free_source;
    logic                   r_err_unexpected;
    logic                   r_err_interleave;
    logic                   r_err_size;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_is_data;
    logic                   w_size_err;
    logic                   w_multi;
    logic [3:0]             w_shift;
    logic [CNT_W:0]         w_beats;
    logic [CNT_W-1:0]       w_beats_m1;
    logic                   w_interleave;
    logic [CNT_W-1:0]       w_cnt_eff;
    logic                   w_first;
    logic                   w_last;

    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_is_data  = (bus.in_opcode == 3'd1) || (bus.in_opcode == 3'd5);
    assign w_size_err = bus.in_size > MAX_SZ;
    assign w_multi    = w_is_data & ~w_size_err & (bus.in_size > BB_SZ);
    assign w_shift    = bus.in_size - BB_SZ;
    assign w_beats    = (CNT_W + 1)'(1) << w_shift;
    assign w_beats_m1 = w_multi ? CNT_W'(w_beats - (CNT_W + 1)'(1)) : '0;

    // A source change mid-burst abandons the old burst and restarts the count.
    assign w_interleave = (r_state == S_BURST) && (bus.in_source != r_burst_src);
    assign w_cnt_eff    = w_interleave ? '0 : r_cnt;
    assign w_first      = (w_cnt_eff == '0);
    assign w_last       = (w_cnt_eff == w_beats_m1);

    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            w_next_state = w_last ? S_IDLE : S_BURST;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt            <= '0;
            r_burst_src      <= '0;
            r_out_valid      <= 1'b0;
            r_out_opcode     <= '0;
            r_out_source     <= '0;
            r_out_beat       <= '0;
            r_out_first      <= 1'b0;
            r_out_last       <= 1'b0;
            r_free_valid     <= 1'b0;
            r_free_source    <= '0;
            r_err_unexpected <= 1'b0;
            r_err_interleave <= 1'b0;
            r_err_size       <= 1'b0;
        end else begin
            r_free_valid <= w_accept & w_last;
            if (w_accept) begin
                r_cnt         <= w_last ? '0 : w_cnt_eff + CNT_W'(1);
                r_burst_src   <= bus.in_source;
                r_out_valid   <= 1'b1;
                r_out_opcode  <= bus.in_opcode;
                r_out_source  <= bus.in_source;
                r_out_beat    <= w_cnt_eff;
                r_out_first   <= w_first;
                r_out_last    <= w_last;
                r_free_source <= bus.in_source;
                if (w_interleave) r_err_interleave <= 1'b1;
                if (w_size_err)   r_err_size       <= 1'b1;
                if (w_first && !r_bitmap[bus.in_source]) r_err_unexpected <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Alloc is applied after free so a same-edge alloc keeps the bit set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bitmap <= '0;
        end else begin
            if (w_accept && w_last) r_bitmap[bus.in_source]    <= 1'b0;
            if (bus.alloc_valid)    r_bitmap[bus.alloc_source] <= 1'b1;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_opcode     = r_out_opcode;
    assign bus.out_source     = r_out_source;
    assign bus.out_beat       = r_out_beat;
    assign bus.out_first      = r_out_first;
    assign bus.out_last       = r_out_last;
    assign bus.free_valid     = r_free_valid;
    assign bus.free_source    = r_free_source;
    assign bus.err_unexpected = r_err_unexpected;
    assign bus.err_interleave = r_err_interleave;
    assign bus.err_size       = r_err_size;
endmodule
